// File: rtl/gsram_dp_param.sv
// Generic dual-port SRAM wrapper: lane write masks, port-0 write priority, post-reset clear; GSRAM_RDW_BYPASS_EN enables cross-port read/write bypass.
// Read latency RD_LAT (1 or 2) cycles; no backpressure, ports ignored while INIT_BUSY.
module gsram_dp_param #(
  parameter int ABITS          = 12,
  parameter int DBITS          = 4,
  parameter int MASKW          = 1,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ABITS-1:0]         A0,
  input  logic [DBITS-1:0]         D0,
  input  logic                     WE0,
  input  logic [DBITS/MASKW-1:0]   WEM0,
  input  logic                     CE0,
  output logic [DBITS-1:0]         Q0,
  input  logic [ABITS-1:0]         A1,
  input  logic [DBITS-1:0]         D1,
  input  logic                     WE1,
  input  logic [DBITS/MASKW-1:0]   WEM1,
  input  logic                     CE1,
  output logic [DBITS-1:0]         Q1,
  output logic                     INIT_BUSY
);

  localparam int NLANE = DBITS / MASKW;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [ABITS-1:0] cnt, cnt_nxt;

  logic [DBITS-1:0] mem [0:(1<<ABITS)-1];

  logic             run, clr_we;
  logic             wr0, wr1, rd0, rd1;
  logic [DBITS-1:0] old0, old1, wdat0, wdat1, rword0, rword1;
  logic [DBITS-1:0] s1_0, s1_1, s2_0, s2_1;
  logic             v1_0, v1_1;

  function automatic logic [DBITS-1:0] lane_merge(input logic [DBITS-1:0] base,
                                                  input logic [DBITS-1:0] din,
                                                  input logic [NLANE-1:0] m);
    lane_merge = base;
    for (int i = 0; i < NLANE; i++)
      if (m[i]) lane_merge[i*MASKW +: MASKW] = din[i*MASKW +: MASKW];
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == S_CLEAR) begin
      cnt_nxt = cnt + ABITS'(1);
      if (&cnt) state_nxt = S_RUN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign INIT_BUSY = (state == S_CLEAR);

  // Array is only ever touched synchronously, and never while reset is held.
  assign run    = (state == S_RUN) && !RST;
  assign clr_we = (state == S_CLEAR) && !RST;
  assign wr0    = run && CE0 && WE0;
  assign wr1    = run && CE1 && WE1;
  assign rd0    = run && CE0 && !WE0;
  assign rd1    = run && CE1 && !WE1;

  assign old0  = mem[A0];
  assign old1  = mem[A1];
  // Port 0 merges on top of port 1's result, so shared lanes end with port 0 data.
  assign wdat1 = lane_merge(old1, D1, WEM1);
  assign wdat0 = lane_merge((wr1 && (A1 == A0)) ? wdat1 : old0, D0, WEM0);

`ifdef GSRAM_RDW_BYPASS_EN
  assign rword0 = (wr1 && (A1 == A0)) ? wdat1 : old0;
  assign rword1 = (wr0 && (A0 == A1)) ? wdat0 : old1;
`else
  assign rword0 = old0;
  assign rword1 = old1;
`endif

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else begin
      if (wr1) mem[A1] <= wdat1;
      if (wr0) mem[A0] <= wdat0;
    end
  end

  // Stage 2 only loads when stage 1 took a read the previous cycle, so Q holds otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_0 <= '0;
      s1_1 <= '0;
      s2_0 <= '0;
      s2_1 <= '0;
      v1_0 <= 1'b0;
      v1_1 <= 1'b0;
    end else begin
      v1_0 <= rd0;
      v1_1 <= rd1;
      if (rd0) s1_0 <= rword0;
      if (rd1) s1_1 <= rword1;
      if (v1_0) s2_0 <= s1_0;
      if (v1_1) s2_1 <= s1_1;
    end
  end

  assign Q0 = (RD_LAT == 2) ? s2_0 : s1_0;
  assign Q1 = (RD_LAT == 2) ? s2_1 : s1_1;

endmodule

// File: tb/tb_gsram_dp_param.sv
// Scoreboard bench: randomized traffic against an array model, plus directed collision and latency cases.
module tb_gsram_dp_param;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  a0 = '0, a1 = '0;
  logic [15:0] d0 = '0, d1 = '0;
  logic        we0 = 1'b0, we1 = 1'b0, ce0 = 1'b0, ce1 = 1'b0;
  logic [1:0]  wem0 = '0, wem1 = '0;
  logic [15:0] q0, q1, q0b, q1b, q0c, q1c;
  logic        busy, busy_b, busy_c;

  always #5 CLK = ~CLK;

  gsram_dp_param #(.ABITS(4), .DBITS(16), .MASKW(8), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut (
    .CLK(CLK), .RST(RST),
    .A0(a0), .D0(d0), .WE0(we0), .WEM0(wem0), .CE0(ce0), .Q0(q0),
    .A1(a1), .D1(d1), .WE1(we1), .WEM1(wem1), .CE1(ce1), .Q1(q1),
    .INIT_BUSY(busy));

  gsram_dp_param #(.ABITS(4), .DBITS(16), .MASKW(8), .RD_LAT(2), .CLEAR_ON_RESET(1)) dut_lat2 (
    .CLK(CLK), .RST(RST),
    .A0(a0), .D0(d0), .WE0(we0), .WEM0(wem0), .CE0(ce0), .Q0(q0b),
    .A1(a1), .D1(d1), .WE1(we1), .WEM1(wem1), .CE1(ce1), .Q1(q1b),
    .INIT_BUSY(busy_b));

  gsram_dp_param #(.ABITS(4), .DBITS(16), .MASKW(8), .RD_LAT(1), .CLEAR_ON_RESET(0)) dut_noclr (
    .CLK(CLK), .RST(RST),
    .A0(a0), .D0(d0), .WE0(we0), .WEM0(wem0), .CE0(ce0), .Q0(q0c),
    .A1(a1), .D1(d1), .WE1(we1), .WEM1(wem1), .CE1(ce1), .Q1(q1c),
    .INIT_BUSY(busy_c));

  typedef struct {
    int          due;
    logic [15:0] val;
  } ent_t;

  ent_t        sb0[$], sb1[$], sb0b[$], sb1b[$];
  logic [15:0] model [16];
  int          cyc = 0;
  int          drv_clr = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: retire expected read data as it falls due, and check every output every cycle.
  logic [15:0] cur0 = '0, cur1 = '0, cur0b = '0, cur1b = '0;
  int          mclr = 0;
  always @(posedge CLK) begin
    #1;
    if (RST) begin
      sb0.delete(); sb1.delete(); sb0b.delete(); sb1b.delete();
      cur0 = '0; cur1 = '0; cur0b = '0; cur1b = '0;
      mclr = 16;
      chk("noclr_q0_in_reset", q0c, 16'h0);
      chk("noclr_q1_in_reset", q1c, 16'h0);
    end else if (mclr > 0) begin
      mclr--;
    end
    while (sb0.size() > 0 && sb0[0].due <= cyc) begin cur0 = sb0[0].val; sb0.delete(0); end
    while (sb1.size() > 0 && sb1[0].due <= cyc) begin cur1 = sb1[0].val; sb1.delete(0); end
    while (sb0b.size() > 0 && sb0b[0].due <= cyc) begin cur0b = sb0b[0].val; sb0b.delete(0); end
    while (sb1b.size() > 0 && sb1b[0].due <= cyc) begin cur1b = sb1b[0].val; sb1b.delete(0); end
    chk("busy", {15'h0, busy}, {15'h0, (RST || mclr > 0)});
    chk("busy_lat2", {15'h0, busy_b}, {15'h0, (RST || mclr > 0)});
    chk("busy_noclr", {15'h0, busy_c}, 16'h0);
    chk("q0", q0, cur0);
    chk("q1", q1, cur1);
    chk("q0_lat2", q0b, cur0b);
    chk("q1_lat2", q1b, cur1b);
  end

  // One clock of stimulus; the model is updated with the access that the next edge performs.
  task automatic step(input logic c0, input logic w0, input logic [1:0] m0, input logic [3:0] ad0,
                      input logic [15:0] dd0, input logic c1, input logic w1, input logic [1:0] m1,
                      input logic [3:0] ad1, input logic [15:0] dd1);
    logic [15:0] r0, r1;
    @(negedge CLK);
    ce0 = c0; we0 = w0; wem0 = m0; a0 = ad0; d0 = dd0;
    ce1 = c1; we1 = w1; wem1 = m1; a1 = ad1; d1 = dd1;
    if (drv_clr > 0) begin
      drv_clr--;
    end else begin
      r0 = model[ad0];
      r1 = model[ad1];
`ifdef GSRAM_RDW_BYPASS_EN
      if (c1 && w1 && ad1 == ad0) begin
        if (m1[0]) r0[7:0]  = dd1[7:0];
        if (m1[1]) r0[15:8] = dd1[15:8];
      end
      if (c0 && w0 && ad0 == ad1) begin
        if (m0[0]) r1[7:0]  = dd0[7:0];
        if (m0[1]) r1[15:8] = dd0[15:8];
      end
`endif
      if (c1 && w1) begin
        if (m1[0]) model[ad1][7:0]  = dd1[7:0];
        if (m1[1]) model[ad1][15:8] = dd1[15:8];
      end
      if (c0 && w0) begin
        if (m0[0]) model[ad0][7:0]  = dd0[7:0];
        if (m0[1]) model[ad0][15:8] = dd0[15:8];
      end
      if (c0 && !w0) begin
        sb0.push_back('{cyc + 1, r0});
        sb0b.push_back('{cyc + 2, r0});
      end
      if (c1 && !w1) begin
        sb1.push_back('{cyc + 1, r1});
        sb1b.push_back('{cyc + 2, r1});
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0);
  endtask

  task automatic junk();
    step(1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom),
         1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom));
  endtask

  // Release at a negedge: the following edge is the first of 16 clear edges.
  task automatic do_reset(input int hold);
    @(negedge CLK);
    RST = 1'b1;
    ce0 = 1'($urandom); ce1 = 1'($urandom);
    repeat (hold) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0;
    drv_clr = 15;
  endtask

  task automatic random_phase(input int n);
    logic [3:0] ra0, ra1;
    for (int k = 0; k < n; k++) begin
      ra0 = 4'($urandom);
      ra1 = ($urandom_range(0, 2) == 0) ? ra0 : 4'($urandom);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), ra0, 16'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), ra1, 16'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);
    repeat (15) junk();
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, 2'b00, 4'(i), 16'h0, 1'b1, 1'b0, 2'b00, 4'(15 - i), 16'h0);
    idle();
    chk("cleared_q0", q0, 16'h0);

    step(1'b1, 1'b1, 2'b11, 4'd3, 16'hA5C3, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    step(1'b1, 1'b1, 2'b01, 4'd3, 16'h00FF, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    step(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 1'b0, 2'b00, 4'd3, 16'h0);
    idle();
    chk("masked_write_q1", q1, 16'hA5FF);

    step(1'b1, 1'b1, 2'b11, 4'd7, 16'h1111, 1'b1, 1'b1, 2'b11, 4'd7, 16'h2222);
    step(1'b1, 1'b0, 2'b00, 4'd7, 16'h0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    idle();
    chk("ww_full_prio", q0, 16'h1111);
    step(1'b1, 1'b1, 2'b01, 4'd7, 16'h1111, 1'b1, 1'b1, 2'b11, 4'd7, 16'h2222);
    step(1'b1, 1'b0, 2'b00, 4'd7, 16'h0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    idle();
    chk("ww_lane_prio", q0, 16'h2211);

    step(1'b1, 1'b1, 2'b11, 4'd5, 16'h0F0F, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    step(1'b1, 1'b1, 2'b11, 4'd5, 16'hBEEF, 1'b1, 1'b0, 2'b00, 4'd5, 16'h0);
    idle();
`ifdef GSRAM_RDW_BYPASS_EN
    chk("rw_collision_q1", q1, 16'hBEEF);
`else
    chk("rw_collision_q1", q1, 16'h0F0F);
`endif
    step(1'b0, 1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 1'b0, 2'b00, 4'd5, 16'h0);
    idle();
    chk("rw_collision_after", q1, 16'hBEEF);

    step(1'b1, 1'b1, 2'b11, 4'd1, 16'h0001, 1'b1, 1'b1, 2'b11, 4'd2, 16'h0002);
    step(1'b1, 1'b0, 2'b00, 4'd1, 16'h0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    step(1'b1, 1'b0, 2'b00, 4'd2, 16'h0, 1'b0, 1'b0, 2'b00, 4'd0, 16'h0);
    idle();
    chk("lat2_first", q0b, 16'h0001);
    idle();
    chk("lat2_second", q0b, 16'h0002);
    idle();
    chk("lat2_hold", q0b, 16'h0002);

    random_phase(500);

    do_reset(2);
    repeat (8) junk();
    do_reset(2);
    repeat (15) junk();
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, 2'b00, 4'(i), 16'h0, 1'b1, 1'b0, 2'b00, 4'(i), 16'h0);
    random_phase(200);
    repeat (4) idle();

    chk("sb_drained", 16'(sb0.size() + sb1.size() + sb0b.size() + sb1b.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
